ddr2_init_checker: RTL
======================

# ddr2_init_checker

Synthesizable DDR2 device-side init monitor. It sits on the controller-to-SDRAM command bus (cke, ba, cmd, addr) and checks the JEDEC power-up sequence: command order, mode-register key fields, inter-command spacing and CKE behaviour. It latches the decoded MR/EMR1 settings and reports `init_done`, or the first error with a code. It serves as the responder-side model in benches and as a hardware sanity monitor in the controller.

## Interface
- `BA_BITS`, 3, bank address width
- `ADDR_BITS`, 14, address width
- `TRP_CYC`, 3, minimum cycles from PRE to the next command
- `TMRD_CYC`, 2, minimum cycles from LM to the next command
- `TRFC_CYC`, 26, minimum cycles from AREF to the next command
- `CKE_NOP_CYC`, 80, minimum cycles of CKE high with NOP/DESEL before the first command

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cke`  in  1  clock enable from the controller
- `ba`  in  BA_BITS  bank address
- `cmd`  in  4  {cs_n, ras_n, cas_n, we_n}
- `addr`  in  ADDR_BITS  address bus
- `init_done`  out  1  sequence completed without error (sticky)
- `err`  out  1  sticky error flag
- `err_code`  out  3  first error: 1 unexpected cmd, 2 timing, 3 CKE settle, 4 CKE drop, 5 bad field
- `cas_lat`  out  3  MR A6:4
- `bl8`  out  1  MR A2:0==3'b011 (0 means BL4)
- `wr_rec`  out  3  MR A11:9 + 1
- `add_lat`  out  3  EMR1 A5:3 from the final EMR1 write
- `dll_en`  out  1  ~EMR1 A0

## Operation
- Commands: NOP 0111, PRE 0010, AREF 0001, LM 0000. Any cmd with cmd[3]=1 (DESEL) is treated as NOP. Every other encoding is unexpected (code 1).
- Expected sequence, one state per step:
  1. W_CKE: wait for cke high.
  2. W_SETTLE: count cycles while cke is high.
  3. PRE1 with A10=1.
  4. EMR2: LM, ba=010.
  5. EMR3: LM, ba=011.
  6. EMR1: LM, ba=001, A0=0.
  7. MR_RST: LM, ba=000, A8=1.
  8. PRE2 with A10=1.
  9. AREF1.
  10. AREF2.
  11. MR: LM, ba=000, A8=0.
  12. OCD_DEF: LM, ba=001, A9:7=111.
  13. OCD_EXIT: LM, ba=001, A9:7=000.
  14. DONE.
- ERR is a terminal state. DONE and ERR exit only on reset.
- In each state a non-NOP command advances only if it matches the expected cmd and fields:
  - Wrong command: code 1.
  - Right command with wrong ba, A10, A8, A0 or A9:7: code 5.
- Decoded outputs update as follows:
  - MR and MR_RST update `cas_lat`, `bl8` and `wr_rec`.
  - EMR1 and OCD_EXIT update `add_lat` and `dll_en`.
- Gap counter: reset to 0 on every non-NOP command, +1 each cycle, saturating at 255. A command at gap k is legal if k ≥ the requirement of the previous command: TRP_CYC after PRE, TMRD_CYC after LM, TRFC_CYC after AREF. Otherwise code 2.
- Settle counter: counts cycles with cke=1 from reset. The PRE1 command needs a count ≥ CKE_NOP_CYC, otherwise code 3.
- Any non-NOP command while cke=0, before DONE: code 1.
- cke falling after it was sampled high, before DONE: code 4.
- In DONE, checking stops. A trailing PRE and normal traffic are ignored.
- Simultaneous error conditions in one cycle: lowest code wins. Only the first error is latched. Later errors are ignored.

## Timing
- All inputs are sampled on posedge clk. All outputs are registered.
- `init_done`, `err`, `err_code` and the decoded fields update 1 cycle after the sampled command.
- Reset values:
  - `init_done`=0, `err`=0, `err_code`=0.
  - `cas_lat`=0, `bl8`=0, `wr_rec`=0, `add_lat`=0, `dll_en`=0.
  - FSM=W_CKE, both counters 0.
- Reset asserted mid-sequence returns everything to reset values immediately (asynchronously).
- Gap boundary: PRE at cycle t and LM at t+TRP_CYC passes. LM at t+TRP_CYC−1 fails with code 2.

## Test plan
- Nominal: cke high for 99 cycles, then the full sequence (LM spacing 2, PRE→next 3, AREF spacing 26, MR addr 0x0432, EMR1 addr 0x0008) → `init_done`=1 one cycle after OCD_EXIT; `cas_lat`=3, `bl8`=0, `wr_rec`=3, `add_lat`=1, `dll_en`=1, `err`=0.
- Timing violation: LM (EMR2) issued 2 cycles after PRE1 → `err`=1, `err_code`=2; `init_done` stays 0 for the rest of the run.
- Bad field: EMR3 issued with ba=001 → `err_code`=5. A later AREF violation still leaves `err_code`=5.
- CKE: PRE1 after only 79 settle cycles → `err_code`=3. Separate run: cke drops after AREF1 → `err_code`=4.
- Unexpected command: AREF in place of PRE2 → `err_code`=1. Separate run: ACT (0011) after DONE → no error.
- Reset mid-sequence: assert rst_n low after MR_RST, then replay the nominal sequence → all outputs zero during reset, `init_done`=1 at the end.

Source files
------------

// File: rtl/ddr2_init_checker.sv
// -----------------------------------------------------------------------------
// ddr2_init_checker
//
// Device-side monitor for the DDR2 power-up / initialisation sequence. It
// watches the controller-to-SDRAM command bus and checks:
//   - command order (PRE, EMR2, EMR3, EMR1, MR+DLL reset, PRE, AREF, AREF,
//     MR, OCD default, OCD exit),
//   - key address / bank fields of each step,
//   - minimum spacing after PRE, LM and AREF,
//   - CKE settle time before the first command and CKE never dropping.
// The MR / EMR1 settings written during the sequence are decoded and held.
// Only the first error is recorded; after DONE or an error the monitor stops
// checking until the next reset.
//
// Ports
//   clk        in   clock, all inputs sampled on the rising edge
//   rst_n      in   asynchronous active-low reset
//   cke        in   clock enable from the controller
//   ba         in   bank address [BA_BITS-1:0]
//   cmd        in   {cs_n, ras_n, cas_n, we_n}
//   addr       in   address bus [ADDR_BITS-1:0] (ADDR_BITS >= 13)
//   init_done  out  sequence completed without error (sticky)
//   err        out  sticky error flag
//   err_code   out  first error: 1 unexpected cmd, 2 timing, 3 CKE settle,
//                   4 CKE drop, 5 bad field
//   cas_lat    out  MR A6:4
//   bl8        out  MR A2:0 == 3'b011 (0 means BL4)
//   wr_rec     out  MR A11:9 + 1
//   add_lat    out  EMR1 A5:3 from the last accepted EMR1-space write
//   dll_en     out  ~EMR1 A0
// -----------------------------------------------------------------------------
module ddr2_init_checker #(
  parameter int unsigned BA_BITS     = 3,
  parameter int unsigned ADDR_BITS   = 14,
  parameter int unsigned TRP_CYC     = 3,
  parameter int unsigned TMRD_CYC    = 2,
  parameter int unsigned TRFC_CYC    = 26,
  parameter int unsigned CKE_NOP_CYC = 80
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic [BA_BITS-1:0]   ba,
  input  logic [3:0]           cmd,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 init_done,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic [2:0]           cas_lat,
  output logic                 bl8,
  output logic [2:0]           wr_rec,
  output logic [2:0]           add_lat,
  output logic                 dll_en
);

  // Command encodings {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LM   = 4'b0000;

  // Sequence states: each names the step the monitor is waiting for
  localparam logic [3:0] S_W_CKE    = 4'd0;
  localparam logic [3:0] S_W_SETTLE = 4'd1;
  localparam logic [3:0] S_PRE1     = 4'd2;
  localparam logic [3:0] S_EMR2     = 4'd3;
  localparam logic [3:0] S_EMR3     = 4'd4;
  localparam logic [3:0] S_EMR1     = 4'd5;
  localparam logic [3:0] S_MR_RST   = 4'd6;
  localparam logic [3:0] S_PRE2     = 4'd7;
  localparam logic [3:0] S_AREF1    = 4'd8;
  localparam logic [3:0] S_AREF2    = 4'd9;
  localparam logic [3:0] S_MR       = 4'd10;
  localparam logic [3:0] S_OCD_DEF  = 4'd11;
  localparam logic [3:0] S_OCD_EXIT = 4'd12;
  localparam logic [3:0] S_DONE     = 4'd13;
  localparam logic [3:0] S_ERR      = 4'd14;

  // Error codes
  localparam logic [2:0] E_CMD    = 3'd1;
  localparam logic [2:0] E_TIMING = 3'd2;
  localparam logic [2:0] E_SETTLE = 3'd3;
  localparam logic [2:0] E_CKE    = 3'd4;
  localparam logic [2:0] E_FIELD  = 3'd5;

  // Counters are 8 bits and saturate; requirements are sized to match
  localparam logic [7:0] CNT_MAX  = 8'hFF;
  localparam logic [7:0] TRP_REQ  = 8'(TRP_CYC);
  localparam logic [7:0] TMRD_REQ = 8'(TMRD_CYC);
  localparam logic [7:0] TRFC_REQ = 8'(TRFC_CYC);
  localparam logic [7:0] CKE_REQ  = 8'(CKE_NOP_CYC);

  // Bank selectors for the mode-register spaces
  localparam logic [BA_BITS-1:0] BA_MR   = BA_BITS'(0);
  localparam logic [BA_BITS-1:0] BA_EMR1 = BA_BITS'(1);
  localparam logic [BA_BITS-1:0] BA_EMR2 = BA_BITS'(2);
  localparam logic [BA_BITS-1:0] BA_EMR3 = BA_BITS'(3);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0] state_q,     state_d;
  logic [7:0] settle_q,    settle_d;   // cycles sampled with cke=1
  logic [7:0] gap_q,       gap_d;      // NOP cycles since the last command
  logic [7:0] req_q,       req_d;      // spacing owed by the last command
  logic       init_done_q, init_done_d;
  logic       err_q,       err_d;
  logic [2:0] err_code_q,  err_code_d;
  logic [2:0] cas_lat_q,   cas_lat_d;
  logic       bl8_q,       bl8_d;
  logic [2:0] wr_rec_q,    wr_rec_d;
  logic [2:0] add_lat_q,   add_lat_d;
  logic       dll_en_q,    dll_en_d;

  // Address bits above A11 carry no init-sequence information.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_BITS-1:12];

  // ---------------------------------------------------------------------------
  // Command decode and per-state expectation
  // ---------------------------------------------------------------------------
  logic       is_nop;
  logic       checking;
  logic [3:0] exp_cmd;
  logic       field_ok;
  logic [3:0] adv_state;
  logic       upd_mr;
  logic       upd_emr;
  logic       pre1_step;

  // DESEL (cs_n high) behaves exactly like NOP.
  assign is_nop   = cmd[3] || (cmd == CMD_NOP);
  assign checking = (state_q != S_DONE) && (state_q != S_ERR);

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    exp_cmd   = CMD_NOP;
    field_ok  = 1'b1;
    adv_state = state_q;
    upd_mr    = 1'b0;
    upd_emr   = 1'b0;
    pre1_step = 1'b0;
    case (state_q)
      // A PRE before the settle time has elapsed is still "PRE1", just early,
      // so the settle check (code 3) rather than code 1 reports it.
      S_W_CKE, S_W_SETTLE, S_PRE1: begin
        exp_cmd   = CMD_PRE;
        field_ok  = addr[10];
        adv_state = S_EMR2;
        pre1_step = 1'b1;
      end
      S_EMR2: begin
        exp_cmd   = CMD_LM;
        field_ok  = (ba == BA_EMR2);
        adv_state = S_EMR3;
      end
      S_EMR3: begin
        exp_cmd   = CMD_LM;
        field_ok  = (ba == BA_EMR3);
        adv_state = S_EMR1;
      end
      S_EMR1: begin
        exp_cmd   = CMD_LM;
        field_ok  = (ba == BA_EMR1) && !addr[0];
        adv_state = S_MR_RST;
        upd_emr   = 1'b1;
      end
      S_MR_RST: begin
        exp_cmd   = CMD_LM;
        field_ok  = (ba == BA_MR) && addr[8];
        adv_state = S_PRE2;
        upd_mr    = 1'b1;
      end
      S_PRE2: begin
        exp_cmd   = CMD_PRE;
        field_ok  = addr[10];
        adv_state = S_AREF1;
      end
      S_AREF1: begin
        exp_cmd   = CMD_AREF;
        adv_state = S_AREF2;
      end
      S_AREF2: begin
        exp_cmd   = CMD_AREF;
        adv_state = S_MR;
      end
      S_MR: begin
        exp_cmd   = CMD_LM;
        field_ok  = (ba == BA_MR) && !addr[8];
        adv_state = S_OCD_DEF;
        upd_mr    = 1'b1;
      end
      S_OCD_DEF: begin
        exp_cmd   = CMD_LM;
        field_ok  = (ba == BA_EMR1) && (addr[9:7] == 3'b111);
        adv_state = S_OCD_EXIT;
      end
      S_OCD_EXIT: begin
        exp_cmd   = CMD_LM;
        field_ok  = (ba == BA_EMR1) && (addr[9:7] == 3'b000);
        adv_state = S_DONE;
        upd_emr   = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Error conditions (only meaningful while checking)
  // ---------------------------------------------------------------------------
  logic [8:0] gap_k;
  logic       e_cmd, e_timing, e_settle, e_cke, e_field;

  // gap_q is 0 on the cycle after a command, so the command now being sampled
  // sits gap_q+1 cycles after the previous one.
  assign gap_k = {1'b0, gap_q} + 9'd1;

  assign e_cmd    = !is_nop && (!cke || (cmd != exp_cmd));
  assign e_timing = !is_nop && (gap_k < {1'b0, req_q});
  assign e_settle = !is_nop && pre1_step && (cmd == CMD_PRE) && (settle_q < CKE_REQ);
  // Leaving W_CKE means cke has been sampled high at least once.
  assign e_cke    = (state_q != S_W_CKE) && !cke;
  assign e_field  = !is_nop && (cmd == exp_cmd) && !field_ok;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    cas_lat_d   = cas_lat_q;
    bl8_d       = bl8_q;
    wr_rec_d    = wr_rec_q;
    add_lat_d   = add_lat_q;
    dll_en_d    = dll_en_q;

    settle_d = (cke && (settle_q != CNT_MAX)) ? settle_q + 8'd1 : settle_q;

    if (!is_nop) begin
      gap_d = '0;
    end else if (gap_q != CNT_MAX) begin
      gap_d = gap_q + 8'd1;
    end else begin
      gap_d = gap_q;
    end

    req_d = req_q;
    if (!is_nop) begin
      case (cmd)
        CMD_PRE:  req_d = TRP_REQ;
        CMD_LM:   req_d = TMRD_REQ;
        CMD_AREF: req_d = TRFC_REQ;
        default:  req_d = '0;
      endcase
    end

    if (checking) begin
      if (e_cmd || e_timing || e_settle || e_cke || e_field) begin
        state_d = S_ERR;
        err_d   = 1'b1;
        // Lowest code wins when several conditions hit in the same cycle.
        if (e_cmd)         err_code_d = E_CMD;
        else if (e_timing) err_code_d = E_TIMING;
        else if (e_settle) err_code_d = E_SETTLE;
        else if (e_cke)    err_code_d = E_CKE;
        else               err_code_d = E_FIELD;
      end else if (!is_nop) begin
        state_d = adv_state;
        if (upd_mr) begin
          cas_lat_d = addr[6:4];
          bl8_d     = (addr[2:0] == 3'b011);
          wr_rec_d  = addr[11:9] + 3'd1;
        end
        if (upd_emr) begin
          add_lat_d = addr[5:3];
          dll_en_d  = !addr[0];
        end
        if (adv_state == S_DONE) init_done_d = 1'b1;
      end else if ((state_q == S_W_CKE) && cke) begin
        state_d = S_W_SETTLE;
      end else if ((state_q == S_W_SETTLE) && (settle_d >= CKE_REQ)) begin
        state_d = S_PRE1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_W_CKE;
      settle_q    <= '0;
      gap_q       <= '0;
      req_q       <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      cas_lat_q   <= '0;
      bl8_q       <= 1'b0;
      wr_rec_q    <= '0;
      add_lat_q   <= '0;
      dll_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      gap_q       <= gap_d;
      req_q       <= req_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cas_lat_q   <= cas_lat_d;
      bl8_q       <= bl8_d;
      wr_rec_q    <= wr_rec_d;
      add_lat_q   <= add_lat_d;
      dll_en_q    <= dll_en_d;
    end
  end

  assign init_done = init_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign cas_lat   = cas_lat_q;
  assign bl8       = bl8_q;
  assign wr_rec    = wr_rec_q;
  assign add_lat   = add_lat_q;
  assign dll_en    = dll_en_q;

endmodule
